ui_mode_controller: RTL

UI_MODE_CONTROLLER -- requirements
Module: ui_mode_controller

---
 rtl/ui_mode_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ui_mode_controller.sv
// ui_mode_controller
//   Menu/mode sequencer for the puzzle UI. A cursor selects one of three
//   activities (manual play, solve, generate). Solve and generate start an
//   engine with a one-cycle start pulse and run until the engine reports
//   done, the user backs out, or a frame-count timeout expires.
//   The renderer-facing mode code and cursor are reloaded only on the frame
//   tick (first cycle of hcount==0 && vcount==HEIGHT), so the picture never
//   changes mid-frame.
//
// Ports
//   clk_in        : clock, rising edge
//   reset_in      : synchronous reset, active low
//   hcount/vcount : raster position (13 bits each)
//   btn_*         : debounced single-cycle button pulses
//   solver_done   : solver finished pulse
//   gen_done      : generator finished pulse
//   state_out     : display mode code (0 idle, 1 manual, 2 solver, 3 generate)
//   cursor_out    : highlighted menu item (0 manual, 1 solve, 2 generate)
//   solver_start  : one-cycle solver start command
//   gen_start     : one-cycle generator start command
//   abort_out     : one-cycle abort of a running engine
//   busy_out      : an engine is running
//   error_out     : sticky timeout flag, cleared by btn_select
module ui_mode_controller #(
  parameter int HEIGHT         = 384,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [12:0] hcount,
  input  logic [12:0] vcount,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_select,
  input  logic        btn_back,
  input  logic        solver_done,
  input  logic        gen_done,
  output logic [3:0]  state_out,
  output logic [1:0]  cursor_out,
  output logic        solver_start,
  output logic        gen_start,
  output logic        abort_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);

  typedef enum logic [2:0] {
    ST_MENU       = 3'd0,
    ST_MANUAL     = 3'd1,
    ST_SOLVING    = 3'd2,
    ST_SOLVED     = 3'd3,
    ST_GENERATING = 3'd4
  } state_t;

  state_t             state_q;
  logic [1:0]         cursor_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic               at_tick_pos_q;

  logic               at_tick_pos_s;
  logic               frame_tick_s;
  logic               timeout_s;

  // Renderer code for each FSM state; SOLVED keeps showing the solver screen.
  function automatic logic [3:0] disp_code(input state_t s);
    case (s)
      ST_MENU:       disp_code = 4'b0000;
      ST_MANUAL:     disp_code = 4'b0001;
      ST_SOLVING:    disp_code = 4'b0010;
      ST_SOLVED:     disp_code = 4'b0010;
      ST_GENERATING: disp_code = 4'b0011;
      default:       disp_code = 4'b0000;
    endcase
  endfunction

  // A raster parked on the tick position counts only on its first cycle.
  assign at_tick_pos_s = (hcount == 13'd0) && (vcount == 13'(HEIGHT));
  assign frame_tick_s  = at_tick_pos_s && !at_tick_pos_q;
  assign timeout_s     = frame_tick_s && (frame_cnt_q == CNT_W'(TIMEOUT_FRAMES - 1));

  // Mode FSM with registered command pulses and frame-aligned display outputs.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q       <= ST_MENU;
      cursor_q      <= 2'd0;
      frame_cnt_q   <= '0;
      at_tick_pos_q <= 1'b0;
      state_out     <= 4'b0000;
      cursor_out    <= 2'd0;
      solver_start  <= 1'b0;
      gen_start     <= 1'b0;
      abort_out     <= 1'b0;
      busy_out      <= 1'b0;
      error_out     <= 1'b0;
    end else begin
      at_tick_pos_q <= at_tick_pos_s;
      solver_start  <= 1'b0;
      gen_start     <= 1'b0;
      abort_out     <= 1'b0;

      // Display registers capture the state as it stands at the tick.
      if (frame_tick_s) begin
        state_out  <= disp_code(state_q);
        cursor_out <= cursor_q;
      end

      // A timeout later in this block overrides this clear.
      if (btn_select) begin
        error_out <= 1'b0;
      end

      case (state_q)
        ST_MENU: begin
          if (btn_select) begin
            frame_cnt_q <= '0;
            case (cursor_q)
              2'd0: state_q <= ST_MANUAL;
              2'd1: begin
                state_q      <= ST_SOLVING;
                solver_start <= 1'b1;
                busy_out     <= 1'b1;
              end
              2'd2: begin
                state_q   <= ST_GENERATING;
                gen_start <= 1'b1;
                busy_out  <= 1'b1;
              end
              default: state_q <= ST_MENU;
            endcase
          end else if (btn_up && !btn_down) begin
            cursor_q <= (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
          end else if (btn_down && !btn_up) begin
            cursor_q <= (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
          end
        end

        ST_MANUAL, ST_SOLVED: begin
          if (btn_back) begin
            state_q <= ST_MENU;
          end
        end

        ST_SOLVING, ST_GENERATING: begin
          if (btn_back) begin
            state_q   <= ST_MENU;
            abort_out <= 1'b1;
            busy_out  <= 1'b0;
          end else if ((state_q == ST_SOLVING) && solver_done) begin
            state_q  <= ST_SOLVED;
            busy_out <= 1'b0;
          end else if ((state_q == ST_GENERATING) && gen_done) begin
            // Generated puzzle is handed straight to the player.
            state_q  <= ST_MANUAL;
            busy_out <= 1'b0;
          end else if (timeout_s) begin
            state_q   <= ST_MENU;
            abort_out <= 1'b1;
            busy_out  <= 1'b0;
            error_out <= 1'b1;
          end else if (frame_tick_s) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q  <= ST_MENU;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
